// File: rtl/cdr_tx_prbs_gen_if.sv
// Frame/symbol bundle for the CDR stimulus transmitter.
// master drives start and fcw_trim; slave is the generator.
interface cdr_tx_prbs_gen_if #(
    parameter int PHASE_BITS = 32
);
    logic                  start;
    logic [PHASE_BITS-1:0] fcw_trim;
    logic                  sym_en;
    logic                  bit_out;
    logic signed [7:0]     y_n;
    logic                  busy;
    logic                  done;
    logic [1:0]            state;

    modport master (
        output start, fcw_trim,
        input  sym_en, bit_out, y_n, busy, done, state
    );

    modport slave (
        input  start, fcw_trim,
        output sym_en, bit_out, y_n, busy, done, state
    );
endinterface

// File: rtl/cdr_tx_prbs_gen.sv
// Framed 1010-preamble + PRBS7 symbol source with NCO symbol timing.
// Optional TX_ISI_EN adds a saturating post-cursor tap on y_n.
module cdr_tx_prbs_gen #(
    parameter int                     PHASE_BITS   = 32,
    parameter logic [PHASE_BITS-1:0]  FCW_NOM      = 32'd85_899_345,
    parameter int                     PREAMBLE_LEN = 32,
    parameter int                     PAYLOAD_LEN  = 1024,
    parameter int                     CNT_BITS     = 16,
    parameter logic signed [7:0]      AMP          = 8'sd64,
    parameter logic [6:0]             SEED         = 7'h7F,
    parameter int                     ISI_SHIFT    = 2
) (
    input  logic             clk,
    input  logic             rst,
    cdr_tx_prbs_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PREAMBLE = 2'b01,
        PAYLOAD  = 2'b10,
        TAIL     = 2'b11
    } state_e;

    localparam int W = PHASE_BITS + 2;
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] PRE_LAST = CNT_BITS'(PREAMBLE_LEN - 1);
    localparam logic [CNT_BITS-1:0] PAY_LAST = CNT_BITS'(PAYLOAD_LEN - 1);

    state_e                state_q, state_d;
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic [CNT_BITS-1:0]   sym_cnt_q, sym_cnt_d;
    logic [6:0]            lfsr_q, lfsr_d;
    logic signed [7:0]     y_q, y_d;
    logic                  bit_q, bit_d;
    logic                  sym_en_q, sym_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [W-1:0]          fcw_sum;
    logic [PHASE_BITS-1:0] fcw_eff;
    logic [PHASE_BITS:0]   acc;
    logic                  carry;
    logic [6:0]            lfsr_nxt;
    logic                  sym_bit;
    logic signed [7:0]     sym_lvl;
    logic signed [7:0]     sym_y;

`ifdef TX_ISI_EN
    logic signed [7:0]     lvl_prev_q, lvl_prev_d;
    logic signed [7:0]     tap;
    logic signed [8:0]     isi_sum;
`endif

    // NCO: trimmed FCW clamped to [1, 2^PHASE_BITS-1], carry marks a symbol
    always_comb begin
        fcw_sum = {2'b00, FCW_NOM}
                + {{2{bus.fcw_trim[PHASE_BITS-1]}}, bus.fcw_trim};
        if (fcw_sum[W-1] || fcw_sum == '0) begin
            fcw_eff = {{(PHASE_BITS-1){1'b0}}, 1'b1};
        end else if (fcw_sum[W-2]) begin
            fcw_eff = '1;
        end else begin
            fcw_eff = fcw_sum[PHASE_BITS-1:0];
        end
        acc   = {1'b0, phase_q} + {1'b0, fcw_eff};
        carry = acc[PHASE_BITS];
    end

    // Symbol datapath: next bit, PRBS7 step and the mapped level
    always_comb begin
        lfsr_nxt = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        if (lfsr_nxt == 7'h00) begin
            lfsr_nxt = 7'h01;
        end
        sym_bit = (state_q == PAYLOAD) ? lfsr_q[6] : ~sym_cnt_q[0];
        sym_lvl = sym_bit ? AMP : -AMP;
`ifdef TX_ISI_EN
        tap     = lvl_prev_q >>> ISI_SHIFT;
        isi_sum = {sym_lvl[7], sym_lvl} + {tap[7], tap};
        if (isi_sum[8] != isi_sum[7]) begin
            sym_y = isi_sum[8] ? 8'sh80 : 8'sh7F;
        end else begin
            sym_y = isi_sum[7:0];
        end
`else
        sym_y   = sym_lvl;
`endif
    end

    // Frame sequencer: next state and registered outputs
    always_comb begin
        state_d   = state_q;
        phase_d   = acc[PHASE_BITS-1:0];
        sym_cnt_d = sym_cnt_q;
        lfsr_d    = lfsr_q;
        y_d       = y_q;
        bit_d     = bit_q;
        sym_en_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef TX_ISI_EN
        lvl_prev_d = lvl_prev_q;
`endif
        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (bus.start) begin
                    state_d   = PREAMBLE;
                    busy_d    = 1'b1;
                    sym_cnt_d = '0;
                    lfsr_d    = SEED;
`ifdef TX_ISI_EN
                    lvl_prev_d = '0;
`endif
                end
            end
            PREAMBLE, PAYLOAD: begin
                if (carry) begin
                    sym_en_d  = 1'b1;
                    bit_d     = sym_bit;
                    y_d       = sym_y;
                    sym_cnt_d = sym_cnt_q + CNT_ONE;
`ifdef TX_ISI_EN
                    lvl_prev_d = sym_lvl;
`endif
                    if (state_q == PREAMBLE) begin
                        if (sym_cnt_q == PRE_LAST) begin
                            state_d   = PAYLOAD;
                            sym_cnt_d = '0;
                        end
                    end else begin
                        lfsr_d = lfsr_nxt;
                        if (sym_cnt_q == PAY_LAST) begin
                            state_d = TAIL;
                        end
                    end
                end
            end
            TAIL: begin
                if (carry) begin
                    state_d = IDLE;
                    phase_d = '0;
                    y_d     = '0;
                    bit_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`ifdef TX_ISI_EN
                    lvl_prev_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, async active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            sym_cnt_q <= '0;
            lfsr_q    <= SEED;
            y_q       <= '0;
            bit_q     <= 1'b0;
            sym_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sym_cnt_q <= sym_cnt_d;
            lfsr_q    <= lfsr_d;
            y_q       <= y_d;
            bit_q     <= bit_d;
            sym_en_q  <= sym_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef TX_ISI_EN
    // Previous-symbol level for the post-cursor tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_prev_q <= '0;
        end else begin
            lvl_prev_q <= lvl_prev_d;
        end
    end
`endif

    assign bus.sym_en  = sym_en_q;
    assign bus.bit_out = bit_q;
    assign bus.y_n     = y_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_cdr_tx_prbs_gen.sv
// Bench for cdr_tx_prbs_gen: frame-level reference model checked
// every cycle, plus directed timing, stall, reset and back-to-back cases.
module tb_cdr_tx_prbs_gen;
    localparam int              P    = 6;
    localparam int              L    = 40;
    localparam int              N    = P + L;
    localparam logic [31:0]     NOM  = 32'h4000_0000;
    localparam longint          TWO32 = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int   exp_bit[N];
    int   exp_y[N];

    bit     m_act;
    int     m_idx;
    longint m_ph;
    int     e_sym, e_bit, e_busy, e_done, e_y, e_state;

    cdr_tx_prbs_gen_if #(.PHASE_BITS(32)) bus ();

    cdr_tx_prbs_gen #(
        .PHASE_BITS  (32),
        .FCW_NOM     (NOM),
        .PREAMBLE_LEN(P),
        .PAYLOAD_LEN (L),
        .CNT_BITS    (16),
        .AMP         (8'sd64),
        .SEED        (7'h7F),
        .ISI_SHIFT   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected frame: alternating preamble from 1, then PRBS7 x^7+x^6+1
    function automatic void build_frame();
        int r;
        int prev;
        int lvl;
        int y;
        r = 7'h7F;
        prev = 0;
        for (int i = 0; i < N; i++) begin
            if (i < P) begin
                exp_bit[i] = (i % 2 == 0) ? 1 : 0;
            end else begin
                exp_bit[i] = (r >> 6) & 1;
                r = ((r << 1) & 7'h7F) | (((r >> 6) ^ (r >> 5)) & 1);
                if (r == 0) r = 1;
            end
            lvl = exp_bit[i] ? 64 : -64;
`ifdef TX_ISI_EN
            y = lvl + (prev >>> 2);
            if (y > 127) y = 127;
            if (y < -128) y = -128;
            prev = lvl;
`else
            y = lvl;
`endif
            exp_y[i] = y;
        end
    endfunction

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_idx = 0; m_ph = 0;
        e_sym = 0; e_bit = 0; e_busy = 0;
        e_done = 0; e_y = 0; e_state = 0;
    endtask

    task automatic model_edge(input bit s, input logic [31:0] t);
        longint f;
        e_sym = 0;
        e_done = 0;
        if (!m_act) begin
            if (s) begin
                m_act = 1; m_idx = 0; m_ph = 0; e_busy = 1;
            end
        end else begin
            f = longint'(NOM) + longint'($signed(t));
            if (f < 1) f = 1;
            if (f > TWO32 - 1) f = TWO32 - 1;
            m_ph = m_ph + f;
            if (m_ph >= TWO32) begin
                m_ph = m_ph - TWO32;
                if (m_idx < N) begin
                    e_sym = 1;
                    e_bit = exp_bit[m_idx];
                    e_y = exp_y[m_idx];
                    m_idx++;
                end else begin
                    e_done = 1; e_busy = 0; m_act = 0;
                    e_y = 0; e_bit = 0;
                end
            end
        end
        if (!m_act) e_state = 0;
        else if (m_idx < P) e_state = 1;
        else if (m_idx < N) e_state = 2;
        else e_state = 3;
    endtask

    task automatic cmp_all();
        chk("sym_en", {31'd0, bus.sym_en}, e_sym);
        chk("bit_out", {31'd0, bus.bit_out}, e_bit);
        chk("y_n", bus.y_n, e_y);
        chk("busy", {31'd0, bus.busy}, e_busy);
        chk("done", {31'd0, bus.done}, e_done);
        chk("state", {30'd0, bus.state}, e_state);
    endtask

    task automatic tick();
        bit s;
        logic [31:0] t;
        s = bus.start;
        t = bus.fcw_trim;
        @(posedge clk);
        model_edge(s, t);
        #1;
        cmp_all();
    endtask

    // Runs until done is seen or the budget expires; reports first sym_en tick
    task automatic run_frame(input string tag, input int max,
                             output int first_sym);
        bit got;
        got = 0;
        first_sym = -1;
        for (int i = 1; i <= max && !got; i++) begin
            tick();
            if (bus.sym_en && first_sym < 0) first_sym = i;
            if (bus.done) got = 1;
        end
        chk({tag, "_done_in_budget"}, {31'd0, got}, 1);
    endtask

    initial begin
        int first;
        int cnt;
        int frames;
        build_frame();
        model_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.fcw_trim = '0;
        #3;
        cmp_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();

        // nominal frame: symbol every 4 cycles, first 4 after PREAMBLE entry
        bus.start = 1'b1;
        run_frame("t1", 400, first);
        chk("t1_first_sym_tick", first, 5);
        bus.start = 1'b0;
        repeat (2) tick();

        // stalled NCO: trim cancels FCW, clamps to 1
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.fcw_trim = -NOM;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.sym_en) cnt++;
        end
        chk("t3_no_sym", cnt, 0);
        chk("t3_busy", {31'd0, bus.busy}, 1);
        bus.fcw_trim = '0;
        run_frame("t3", 400, first);
        chk("t3_resume_first", first, 4);

        // randomized trim and random start pulses
        for (int f = 0; f < 3; f++) begin
            bus.start = 1'b1;
            tick();
            for (int i = 0; i < 600 && m_act; i++) begin
                bus.fcw_trim = $urandom_range(32'h1000_0000) - 32'h0800_0000;
                bus.start = 1'($urandom_range(1));
                tick();
            end
            chk("rand_frame_end", {31'd0, bus.busy}, 0);
            bus.start = 1'b0;
            bus.fcw_trim = '0;
            tick();
        end

        // async reset mid-payload
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 400 && m_idx < P + 5; i++) tick();
        chk("t4_in_payload", {30'd0, bus.state}, 2);
        #2 rst = 1'b1;
        model_reset();
        #1;
        cmp_all();
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_frame("t4_replay", 400, first);

        // start held high: back-to-back frames, one IDLE cycle between
        bus.start = 1'b1;
        frames = 0;
        for (int i = 0; i < 1200 && frames < 2; i++) begin
            tick();
            if (bus.done) begin
                frames++;
                tick();
                chk("t5_restart", {30'd0, bus.state}, 1);
            end
        end
        chk("t5_frames", frames, 2);
        bus.start = 1'b0;
        run_frame("t5_last", 400, first);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
